// File: rtl/adc_overrange_monitor_if.sv
// Bundle of per-channel ADC overrange inputs and the status outputs
// reported back to the register interface.
interface adc_overrange_monitor_if #(
  parameter int NCHAN = 2,
  parameter int CNT_W = 16
);
  logic [NCHAN-1:0]       overrange;
  logic                   clear;
  logic [NCHAN-1:0]       clear_mask;
  logic [NCHAN-1:0]       overrange_latched;
  logic                   overrange_any;
  logic [NCHAN-1:0]       overrange_stretch;
  logic [NCHAN*CNT_W-1:0] event_count;

  // The ADC front end and clear source drive the inputs and observe status.
  modport master (
    output overrange,
    output clear,
    output clear_mask,
    input  overrange_latched,
    input  overrange_any,
    input  overrange_stretch,
    input  event_count
  );

  // The monitor itself consumes the inputs and produces status.
  modport slave (
    input  overrange,
    input  clear,
    input  clear_mask,
    output overrange_latched,
    output overrange_any,
    output overrange_stretch,
    output event_count
  );
endinterface

// File: rtl/adc_overrange_monitor.sv
// Multi-channel ADC overrange monitor: sticky flags, saturating event
// counters and pulse-stretched indicators, all in the ADC clock domain.
// A rising edge of clear wipes the flags and counters of the selected
// channels; the stretch indicators are never touched by clear.
module adc_overrange_monitor #(
  parameter int NCHAN       = 2,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 12288000
) (
  input logic                  aclk,
  input logic                  arstn,
  adc_overrange_monitor_if.slave bus
);

  localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);

  logic [NCHAN-1:0]       ovr_d;
  logic                   clear_d;
  logic [NCHAN-1:0]       latched_q;
  logic                   any_q;
  logic [NCHAN-1:0]       stretch_q;
  logic [NCHAN*CNT_W-1:0] count_q;
  logic [TIMER_W-1:0]     timer_q [NCHAN];

  logic [NCHAN-1:0]       ev;
  logic                   clr_ev;
  logic [NCHAN-1:0]       clr_sel;
  logic [NCHAN-1:0]       latched_nxt;

  // Edge detection and next-state sticky flags; overrange beats a clear.
  always_comb begin
    ev          = bus.overrange & ~ovr_d;
    clr_ev      = bus.clear & ~clear_d;
    clr_sel     = {NCHAN{clr_ev}} & bus.clear_mask;
    latched_nxt = latched_q;
    for (int i = 0; i < NCHAN; i++) begin
      if (bus.overrange[i]) begin
        latched_nxt[i] = 1'b1;
      end else if (clr_sel[i]) begin
        latched_nxt[i] = 1'b0;
      end
    end
  end

  // All state: history registers, flags, counters and stretch timers.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      ovr_d     <= '0;
      clear_d   <= 1'b0;
      latched_q <= '0;
      any_q     <= 1'b0;
      stretch_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      ovr_d     <= bus.overrange;
      clear_d   <= bus.clear;
      latched_q <= latched_nxt;
      any_q     <= |latched_nxt;
      for (int i = 0; i < NCHAN; i++) begin
        if (clr_sel[i]) begin
          count_q[i*CNT_W +: CNT_W] <= {{(CNT_W-1){1'b0}}, ev[i]};
        end else if (ev[i] && (count_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          count_q[i*CNT_W +: CNT_W] <= count_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end

        stretch_q[i] <= bus.overrange[i] | (timer_q[i] != '0);
        if (bus.overrange[i]) begin
          timer_q[i] <= TIMER_W'(HOLD_CYCLES);
        end else if (timer_q[i] != '0) begin
          timer_q[i] <= timer_q[i] - TIMER_W'(1);
        end
      end
    end
  end

  assign bus.overrange_latched = latched_q;
  assign bus.overrange_any     = any_q;
  assign bus.overrange_stretch = stretch_q;
  assign bus.event_count       = count_q;

endmodule

// File: tb/tb_adc_overrange_monitor.sv
// Self-checking bench for adc_overrange_monitor (2 channels, 4-bit
// counters, 4-cycle stretch). A behavioural model queues the expected
// outputs for every driven cycle; a monitor pops and compares them after
// each edge, and each scenario task adds its own targeted checks.
module tb_adc_overrange_monitor;

  localparam int NCHAN = 2;
  localparam int CNT_W = 4;
  localparam int HOLD  = 4;

  typedef struct {
    logic [1:0] latched;
    logic       any;
    logic [1:0] stretch;
    logic [7:0] count;
  } exp_t;

  logic aclk;
  logic arstn;
  int   checks;
  int   errors;
  exp_t sb[$];

  // reference model state
  logic [1:0] m_ovr_d;
  logic       m_clr_d;
  logic [1:0] m_latched;
  logic [1:0] m_stretch;
  int         m_cnt   [2];
  int         m_timer [2];

  adc_overrange_monitor_if #(.NCHAN(NCHAN), .CNT_W(CNT_W)) bus ();

  adc_overrange_monitor #(
    .NCHAN(NCHAN),
    .CNT_W(CNT_W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .aclk (aclk),
    .arstn(arstn),
    .bus  (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Drive one cycle of stimulus, advance the model, queue the expectation.
  task automatic drive_cycle(input logic rst_n, input logic [1:0] ov,
                             input logic clr, input logic [1:0] mask);
    exp_t       e;
    logic [1:0] ev;
    logic       ce;
    arstn          = rst_n;
    bus.overrange  = ov;
    bus.clear      = clr;
    bus.clear_mask = mask;
    if (!rst_n) begin
      m_ovr_d = 2'b00; m_clr_d = 1'b0; m_latched = 2'b00; m_stretch = 2'b00;
      for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_timer[i] = 0; end
    end else begin
      ev = ov & ~m_ovr_d;
      ce = clr && !m_clr_d;
      for (int i = 0; i < 2; i++) begin
        if (ov[i]) m_latched[i] = 1'b1;
        else if (ce && mask[i]) m_latched[i] = 1'b0;
        if (ce && mask[i]) m_cnt[i] = ev[i] ? 1 : 0;
        else if (ev[i] && m_cnt[i] < 15) m_cnt[i] = m_cnt[i] + 1;
        m_stretch[i] = ov[i] || (m_timer[i] > 0);
        if (ov[i]) m_timer[i] = HOLD;
        else if (m_timer[i] > 0) m_timer[i] = m_timer[i] - 1;
      end
      m_ovr_d = ov;
      m_clr_d = clr;
    end
    e.latched = m_latched;
    e.any     = |m_latched;
    e.stretch = m_stretch;
    e.count   = {4'(m_cnt[1]), 4'(m_cnt[0])};
    sb.push_back(e);
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard monitor: compare outputs against the model after every edge.
  always @(posedge aclk) begin
    exp_t e;
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks += 4;
      if (bus.overrange_latched !== e.latched) begin
        errors++;
        $display("[TB] FAIL sb_latched t=%0t got=%b exp=%b", $time, bus.overrange_latched, e.latched);
      end
      if (bus.overrange_any !== e.any) begin
        errors++;
        $display("[TB] FAIL sb_any t=%0t got=%b exp=%b", $time, bus.overrange_any, e.any);
      end
      if (bus.overrange_stretch !== e.stretch) begin
        errors++;
        $display("[TB] FAIL sb_stretch t=%0t got=%b exp=%b", $time, bus.overrange_stretch, e.stretch);
      end
      if (bus.event_count !== e.count) begin
        errors++;
        $display("[TB] FAIL sb_count t=%0t got=%h exp=%h", $time, bus.event_count, e.count);
      end
    end
  end

  // Return to a clean state: let stretch drain, then clear both channels.
  task automatic quiesce();
    for (int i = 0; i < HOLD + 2; i++) drive_cycle(1'b1, 2'b00, 1'b0, 2'b00);
    drive_cycle(1'b1, 2'b00, 1'b1, 2'b11);
    drive_cycle(1'b1, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 2'b11, 1'b0, 2'b00);
      checks++;
      if ({bus.overrange_latched, bus.overrange_any, bus.overrange_stretch, bus.event_count} !== 13'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle=%0d got=%b/%b/%b/%h exp=all zero", c,
                 bus.overrange_latched, bus.overrange_any, bus.overrange_stretch, bus.event_count);
      end
    end
    drive_cycle(1'b1, 2'b11, 1'b0, 2'b00);
    checks++;
    if (bus.event_count !== 8'h11) begin
      errors++;
      $display("[TB] FAIL reset_release_count got=%h exp=11", bus.event_count);
    end
    checks++;
    if (bus.overrange_latched !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_release_latched got=%b exp=11", bus.overrange_latched);
    end
    quiesce();
  endtask

  task automatic test_event_stretch();
    logic [5:0] pat;
    $display("[TB] test_event_stretch");
    pat = 6'b101101;
    for (int k = 5; k >= 0; k--) drive_cycle(1'b1, {1'b0, pat[k]}, 1'b0, 2'b00);
    checks++;
    if (bus.event_count !== 8'h03) begin
      errors++;
      $display("[TB] FAIL event_count got=%h exp=03", bus.event_count);
    end
    for (int c = 1; c <= HOLD; c++) begin
      drive_cycle(1'b1, 2'b00, 1'b0, 2'b00);
      checks++;
      if (bus.overrange_stretch[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stretch_hold cycle=%0d got=%b exp=1", c, bus.overrange_stretch[0]);
      end
    end
    drive_cycle(1'b1, 2'b00, 1'b0, 2'b00);
    checks++;
    if (bus.overrange_stretch[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stretch_fall got=%b exp=0", bus.overrange_stretch[0]);
    end
  endtask

  task automatic test_saturation();
    $display("[TB] test_saturation");
    for (int p = 0; p < 20; p++) begin
      drive_cycle(1'b1, 2'b10, 1'b0, 2'b00);
      drive_cycle(1'b1, 2'b00, 1'b0, 2'b00);
    end
    checks++;
    if (bus.event_count[7:4] !== 4'd15) begin
      errors++;
      $display("[TB] FAIL saturate_count got=%0d exp=15", bus.event_count[7:4]);
    end
    checks++;
    if (bus.overrange_latched[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL saturate_latched got=%b exp=1", bus.overrange_latched[1]);
    end
    quiesce();
  endtask

  task automatic test_masked_clear();
    $display("[TB] test_masked_clear");
    for (int p = 0; p < 5; p++) begin
      drive_cycle(1'b1, {1'b1, (p < 3)}, 1'b0, 2'b00);
      drive_cycle(1'b1, 2'b00, 1'b0, 2'b00);
    end
    drive_cycle(1'b1, 2'b00, 1'b1, 2'b01);
    checks++;
    if (bus.overrange_latched !== 2'b10) begin
      errors++;
      $display("[TB] FAIL masked_latched got=%b exp=10", bus.overrange_latched);
    end
    checks++;
    if (bus.event_count !== 8'h50) begin
      errors++;
      $display("[TB] FAIL masked_count got=%h exp=50", bus.event_count);
    end
    checks++;
    if (bus.overrange_any !== 1'b1) begin
      errors++;
      $display("[TB] FAIL masked_any got=%b exp=1", bus.overrange_any);
    end
    drive_cycle(1'b1, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic test_simultaneous();
    $display("[TB] test_simultaneous");
    drive_cycle(1'b1, 2'b01, 1'b1, 2'b01);
    checks++;
    if (bus.overrange_latched[0] !== 1'b1 || bus.event_count[3:0] !== 4'd1) begin
      errors++;
      $display("[TB] FAIL simul_clear_ev got=%b/%0d exp=1/1", bus.overrange_latched[0], bus.event_count[3:0]);
    end
    drive_cycle(1'b1, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic test_clear_edge_only();
    $display("[TB] test_clear_edge_only");
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b1, {1'b0, (c == 5)}, 1'b1, 2'b01);
      if (c == 0) begin
        checks++;
        if (bus.event_count[3:0] !== 4'd0 || bus.overrange_latched[0] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL clear_edge_first got=%0d/%b exp=0/0", bus.event_count[3:0], bus.overrange_latched[0]);
        end
      end
    end
    checks++;
    if (bus.event_count[3:0] !== 4'd1 || bus.overrange_latched[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_edge_level got=%0d/%b exp=1/1", bus.event_count[3:0], bus.overrange_latched[0]);
    end
    drive_cycle(1'b1, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    for (int c = 0; c < 200; c++) begin
      drive_cycle(($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
  endtask

  // Watchdog: the run is clock-bounded, but never allow a hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    arstn = 1'b0;
    bus.overrange = '0;
    bus.clear = 1'b0;
    bus.clear_mask = '0;
    test_reset();
    test_event_stretch();
    test_saturation();
    test_masked_clear();
    test_simultaneous();
    test_clear_edge_only();
    test_random();
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_overrange_monitor.md
# adc_overrange_monitor

Parametrised multi-channel successor to the single-channel ADC overrange latch. It monitors NCHAN ADC overrange flags in the ADC clock domain and provides, per channel:
- a sticky latched flag,
- a saturating count of overrange events,
- a pulse-stretched indicator for LEDs and slow register polling.

A rising edge on `clear` clears the latched flags and counters of the channels selected by `clear_mask`. The block sits between the ADC input stage and the status/register interface.

## Interface
Parameters:
- `NCHAN`, 2, number of ADC channels monitored (1..8).
- `CNT_W`, 16, width of each per-channel event counter (2..32).
- `HOLD_CYCLES`, 12288000, stretch duration in aclk cycles (about 100 ms at 122.88 MHz). Must be ≥1.

Ports:
- `aclk`  in  1  ADC clock; all logic on its rising edge.
- `arstn`  in  1  reset, synchronous, active-low.
- `overrange`  in  NCHAN  per-channel ADC overrange flag, synchronous to aclk. Bit i is channel i.
- `clear`  in  1  clear request. Only its rising edge acts; level is ignored.
- `clear_mask`  in  NCHAN  channels affected by a clear edge. Sampled in the same cycle as the edge.
- `overrange_latched`  out  NCHAN  sticky per-channel flag.
- `overrange_any`  out  1  OR of all `overrange_latched` bits.
- `overrange_stretch`  out  NCHAN  per-channel stretched indicator.
- `event_count`  out  NCHAN*CNT_W  per-channel event counters. Channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- **Reset** (arstn=0 at a clock edge):
  - All outputs go to 0.
  - Internal state goes to 0: `clear` history register, `overrange` history register, hold timers.
  - Reset takes priority over every other event.
- **Event definition:** `ev[i] = overrange[i] & ~ovr_d[i]`, where `ovr_d` is `overrange` registered one cycle. Because `ovr_d` resets to 0, an input held high through reset release counts as one event on the first active cycle.
- **Clear edge:** `clr_ev = clear & ~clear_d`. A clear level held high produces exactly one clear edge.
- **Latched flag, per channel:**
  - If `overrange[i]`=1: set to 1.
  - Else if `clr_ev & clear_mask[i]`: set to 0.
  - Else: hold.
  - Overrange wins over a simultaneous clear.
- **Counter, per channel:**
  - If `clr_ev & clear_mask[i]`: load `ev[i] ? 1 : 0`.
  - Else if `ev[i]` and the count is not all-ones: increment.
  - Else: hold.
  - The counter saturates at 2^CNT_W−1 and never wraps.
- **Stretch timer, per channel** (width $clog2(HOLD_CYCLES+1)):
  - If `overrange[i]`=1: load HOLD_CYCLES.
  - Else if the timer is nonzero: decrement.
  - `overrange_stretch[i]` is registered as `overrange[i] | (timer != 0)`.
  - `clear` does not affect stretch timers or `overrange_stretch`.
- **Unselected channels:** channels with `clear_mask[i]`=0 are unaffected by a clear edge.
- **`overrange_any`:** registered OR of the next-state values of the latched flags. It is therefore cycle-aligned with `overrange_latched`.

## Timing
- All outputs are registered with one-cycle latency. `overrange` high in cycle n gives:
  - `overrange_latched`, `overrange_any` and `overrange_stretch` high after edge n;
  - `event_count` incremented after edge n.
- **Stretch hold:** after the last cycle of `overrange`=1 (cycle n), `overrange_stretch` stays high for exactly HOLD_CYCLES further cycles. It falls after edge n+HOLD_CYCLES+1.
- **Clear:**
  - A clear edge in cycle n takes effect after edge n.
  - `clear` must be low for at least one cycle before another edge is recognised.
- **Continuous overrange:** `overrange` held high for many cycles counts as one event. A 1-0-1 pattern counts as two.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** arstn=0 for 3 cycles with `overrange`=all-ones → all outputs 0 throughout reset. After release, each count is 1 and each latched flag is 1, both one cycle after release.
- **Event counting and stretch** (NCHAN=2, CNT_W=4, HOLD_CYCLES=4):
  - Drive ch0 pulses 1-0-1-1-0-1 → `event_count` ch0 = 3, ch1 = 0.
  - Ch0 `overrange_stretch` stays high from the first pulse until 4 cycles after the last overrange-high cycle, then goes to 0.
- **Saturation** (CNT_W=4): 20 single-cycle pulses on ch1 → count reaches 15 and stays at 15. `overrange_latched[1]`=1.
- **Masked clear:** with both channels latched and counts 3 and 5, `clear` rising with `clear_mask`=2'b01 → ch0 latched=0, count=0; ch1 latched=1, count=5; `overrange_any` remains 1.
- **Simultaneous clear and overrange edge:** `clr_ev` and `ev[0]` in the same cycle with `clear_mask[0]`=1 → latched=1, count=1.
- **Clear edge only:** `clear` held high for 10 cycles with a new ch0 event in cycle 5 → one clear at cycle 0 only. The ch0 count ends at 1 and latched stays 1.
